// File: rtl/seq_det_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// valid-qualified input and a saturating match counter.
module seq_det_prog #(
  parameter int unsigned          MAX_LEN = 16,
  parameter int unsigned          DEF_LEN = 4,
  parameter logic [MAX_LEN-1:0]   DEF_PAT = MAX_LEN'(16'h0006),
  parameter int unsigned          CNT_W   = 8,
  localparam int unsigned         LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               overlap_en,
  input  logic               in_valid,
  input  logic               x,
  input  logic               clr_cnt,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               z_q, z_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] shifted;
  logic [LEN_W-1:0]   len_clamped;
  logic               fill_ok;
  logic               match;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len_q) mask[i] = 1'b1;
    end
  end

  always_comb begin
    if (cfg_len == '0)
      len_clamped = LEN_W'(1);
    else if (cfg_len > LEN_W'(MAX_LEN))
      len_clamped = LEN_W'(MAX_LEN);
    else
      len_clamped = cfg_len;
  end

  // Only bits accepted since the last clear may take part in a match.
  assign shifted = {hist_q[MAX_LEN-2:0], x};
  assign fill_ok = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};
  assign match   = in_valid && !cfg_load && fill_ok &&
                   ((shifted & mask) == (pat_q & mask));

  always_comb begin
    hist_d = hist_q;
    pat_d  = pat_q;
    len_d  = len_q;
    fill_d = fill_q;
    z_d    = match;
    cnt_d  = cnt_q;

    if (cfg_load) begin
      pat_d  = cfg_pat;
      len_d  = len_clamped;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = shifted;
      if (match && !overlap_en)
        fill_d = '0;
      else if (fill_q != LEN_W'(MAX_LEN))
        fill_d = fill_q + LEN_W'(1);
    end

    if (clr_cnt)
      cnt_d = match ? CNT_W'(1) : '0;
    else if (match && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      pat_q  <= DEF_PAT;
      len_q  <= LEN_W'(DEF_LEN);
      fill_q <= '0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      fill_q <= fill_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
    end
  end

  assign z         = z_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: directed scenarios plus random traffic against a
// queue-based model of fresh accepted bits; two DUTs differ only in CNT_W.
module tb_seq_det_prog;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_load;
  logic [15:0] cfg_pat;
  logic [4:0]  cfg_len;
  logic        overlap_en;
  logic        in_valid;
  logic        x;
  logic        clr_cnt;
  logic        z_a, z_b;
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  // Model: bits accepted since the last clear, newest at the back.
  bit          fresh[$];
  logic [15:0] m_pat;
  int          m_len;
  bit          m_z;
  int          m_cnt_a, m_cnt_b;

  seq_det_prog #(.MAX_LEN(16), .DEF_LEN(4), .DEF_PAT(16'h0006), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .overlap_en(overlap_en), .in_valid(in_valid), .x(x),
    .clr_cnt(clr_cnt), .z(z_a), .match_cnt(cnt_a)
  );

  seq_det_prog #(.MAX_LEN(16), .DEF_LEN(4), .DEF_PAT(16'h0006), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .overlap_en(overlap_en), .in_valid(in_valid), .x(x),
    .clr_cnt(clr_cnt), .z(z_b), .match_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    fresh.delete();
    m_pat   = 16'h0006;
    m_len   = 4;
    m_z     = 1'b0;
    m_cnt_a = 0;
    m_cnt_b = 0;
  endtask

  task automatic drive_idle();
    cfg_load = 0; cfg_pat = '0; cfg_len = '0; in_valid = 0; x = 0; clr_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset = 0;
    m_reset();
    @(negedge clk);
    reset = 1;
  endtask

  // One clock: drive at negedge, advance model at the edge, return #1 after it.
  task automatic step(input bit ld, input logic [15:0] p, input int l,
                      input bit v, input bit b, input bit ov, input bit clr);
    bit match;
    bit ok;
    logic [4:0] l5;
    @(negedge clk);
    cfg_load = ld; cfg_pat = p; l5 = 5'(l); cfg_len = l5;
    in_valid = v; x = b; overlap_en = ov; clr_cnt = clr;
    @(posedge clk);
    match = 0;
    if (ld) begin
      m_pat = p;
      m_len = (l5 == 0) ? 1 : ((l5 > 16) ? 16 : int'(l5));
      fresh.delete();
    end else if (v) begin
      fresh.push_back(b);
      if (fresh.size() > 16) void'(fresh.pop_front());
      if (fresh.size() >= m_len) begin
        ok = 1;
        for (int k = 0; k < m_len; k++)
          if (fresh[fresh.size() - 1 - k] != m_pat[k]) ok = 0;
        if (ok) begin
          match = 1;
          if (!ov) fresh.delete();
        end
      end
    end
    m_z = match;
    if (clr) begin
      m_cnt_a = match ? 1 : 0;
      m_cnt_b = match ? 1 : 0;
    end else if (match) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3)   m_cnt_b++;
    end
    #1;
  endtask

  task automatic bit_in(input bit b, input bit ov);
    step(0, '0, 0, 1, b, ov, 0);
  endtask

  task automatic test_reset();
    drive_idle();
    overlap_en = 1;
    reset = 0;
    m_reset();
    #3;
    checks++;
    if (z_a !== 1'b0 || z_b !== 1'b0) begin
      errors++; $display("FAIL reset_z: got a=%b b=%b want 0", z_a, z_b);
    end
    checks++;
    if (cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
      errors++; $display("FAIL reset_cnt: got a=%0d b=%0d want 0", cnt_a, cnt_b);
    end
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_overlap();
    bit s[7] = '{0,1,1,0,1,1,0};
    bit e[7] = '{0,0,0,1,0,0,1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bit_in(s[i], 1);
      checks++;
      if (z_a !== e[i]) begin
        errors++; $display("FAIL overlap_z bit%0d: got %b want %b", i + 1, z_a, e[i]);
      end
    end
    checks++;
    if (cnt_a !== 8'd2) begin
      errors++; $display("FAIL overlap_cnt: got %0d want 2", cnt_a);
    end
  endtask

  task automatic test_nonoverlap();
    bit s[7] = '{0,1,1,0,1,1,0};
    bit e[7] = '{0,0,0,1,0,0,0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bit_in(s[i], 0);
      checks++;
      if (z_a !== e[i]) begin
        errors++; $display("FAIL nonoverlap_z bit%0d: got %b want %b", i + 1, z_a, e[i]);
      end
    end
    checks++;
    if (cnt_a !== 8'd1) begin
      errors++; $display("FAIL nonoverlap_cnt: got %0d want 1", cnt_a);
    end
  endtask

  task automatic test_cfg_101();
    bit s[5] = '{1,0,1,0,1};
    bit e[5] = '{0,0,1,0,1};
    do_reset();
    step(1, 16'h0005, 3, 1, 1, 1, 0);
    checks++;
    if (z_a !== 1'b0) begin
      errors++; $display("FAIL cfg_load_z: got %b want 0", z_a);
    end
    for (int i = 0; i < 5; i++) begin
      bit_in(s[i], 1);
      checks++;
      if (z_a !== e[i]) begin
        errors++; $display("FAIL cfg101_z bit%0d: got %b want %b", i + 1, z_a, e[i]);
      end
    end
  endtask

  task automatic test_gaps();
    bit v[9] = '{1,1,0,0,0,0,0,1,1};
    bit s[9] = '{0,1,1,1,1,1,1,1,0};
    bit e[9] = '{0,0,0,0,0,0,0,0,1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(0, '0, 0, v[i], s[i], 1, 0);
      checks++;
      if (z_a !== e[i]) begin
        errors++; $display("FAIL gaps_z cyc%0d: got %b want %b", i, z_a, e[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit s[4] = '{0,1,1,0};
    bit e[4] = '{0,0,0,1};
    do_reset();
    bit_in(0, 1); bit_in(1, 1); bit_in(1, 1);
    #2 reset = 0;
    m_reset();
    #1;
    checks++;
    if (z_a !== 1'b0 || cnt_a !== 8'd0) begin
      errors++; $display("FAIL midreset: got z=%b cnt=%0d want 0/0", z_a, cnt_a);
    end
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      bit_in(s[i], 1);
      checks++;
      if (z_a !== e[i]) begin
        errors++; $display("FAIL midreset_z bit%0d: got %b want %b", i + 1, z_a, e[i]);
      end
    end
  endtask

  task automatic test_maxlen();
    logic [15:0] p = 16'hA5C3;
    do_reset();
    step(1, p, 20, 0, 0, 1, 0);
    for (int i = 15; i >= 0; i--) begin
      bit_in(p[i], 1);
      checks++;
      if (z_a !== (i == 0)) begin
        errors++; $display("FAIL maxlen_z idx%0d: got %b want %b", i, z_a, (i == 0));
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    step(1, 16'h0001, 1, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      bit_in(1, 1);
      checks++;
      if (z_b !== 1'b1 || cnt_b !== 2'(m_cnt_b) || cnt_a !== 8'(m_cnt_a)) begin
        errors++;
        $display("FAIL sat bit%0d: got z=%b b=%0d a=%0d want 1/%0d/%0d",
                 i + 1, z_b, cnt_b, cnt_a, m_cnt_b, m_cnt_a);
      end
    end
    checks++;
    if (cnt_b !== 2'd3) begin
      errors++; $display("FAIL sat_final: got %0d want 3", cnt_b);
    end
    step(0, '0, 0, 1, 1, 1, 1);
    checks++;
    if (cnt_a !== 8'd1 || cnt_b !== 2'd1) begin
      errors++; $display("FAIL clr_match: got a=%0d b=%0d want 1", cnt_a, cnt_b);
    end
    step(0, '0, 0, 0, 1, 1, 1);
    checks++;
    if (cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
      errors++; $display("FAIL clr_alone: got a=%0d b=%0d want 0", cnt_a, cnt_b);
    end
    step(1, 16'h0001, 0, 1, 0, 1, 0);
    bit_in(1, 1);
    checks++;
    if (z_a !== 1'b1) begin
      errors++; $display("FAIL len0_clamp: got %b want 1", z_a);
    end
  endtask

  task automatic test_random();
    bit ld, v, b, ov, clr;
    int l;
    logic [15:0] p;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ld  = ($urandom_range(0, 39) == 0);
      l   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(1, 4);
      p   = 16'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom);
      ov  = 1'($urandom);
      clr = ($urandom_range(0, 29) == 0);
      step(ld, p, l, v, b, ov, clr);
      checks++;
      if (z_a !== m_z || z_b !== m_z || cnt_a !== 8'(m_cnt_a) || cnt_b !== 2'(m_cnt_b)) begin
        errors++;
        $display("FAIL random cyc%0d: got z=%b/%b cnt=%0d/%0d want z=%b cnt=%0d/%0d",
                 i, z_a, z_b, cnt_a, cnt_b, m_z, m_cnt_a, m_cnt_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_cfg_101();
    test_gaps();
    test_reset_mid();
    test_maxlen();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
